// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte-serial UART transmitter fed by a small byte FIFO. Bytes pushed with a
// one-cycle TxD_start strobe are queued, then shifted out LSB first as 8N1
// frames on TxD. When the macro UART_TX_PARITY_EN is defined, every frame
// also carries an even-parity bit between data bit 7 and the stop bit (8E1).
//
// Parameters:
//   CLK_FREQ   - HCLK frequency in Hz
//   BAUD       - line rate; CLKS_PER_BIT = CLK_FREQ / BAUD (must be >= 2)
//   FIFO_DEPTH - byte entries, power of two, >= 2
//
// Ports:
//   HCLK       in   sole clock, rising edge
//   HRESET     in   asynchronous active-low reset
//   TxD_start  in   push strobe, TxD_data sampled on every edge it is high
//   TxD_data   in   8-bit byte to push
//   TxD        out  registered serial line, idles high
//   TxD_busy   out  frame in progress or FIFO non-empty
//   TxD_done   out  one-cycle pulse when a frame's stop bit completes
//   fifo_full  out  FIFO holds FIFO_DEPTH bytes
//   overflow   out  sticky, set when a push is dropped; cleared by reset only
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       TxD_start,
   input  logic [7:0] TxD_data,
   output logic       TxD,
   output logic       TxD_busy,
   output logic       TxD_done,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int PW           = AW + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   // Storage is not reset: reset empties the FIFO through the pointers.
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            fifo_empty;
   logic            full;
   logic            pop;
   logic            push_ok;
   logic            bit_tick;
   logic [7:0]      head;

   // Pointers carry one extra MSB: equal low bits with differing MSB means full.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   // The transmitter only pops from IDLE, so a same-cycle pop can make room
   // for a push even when the FIFO is full.
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   assign push_ok    = TxD_start && (!full || pop);
   assign bit_tick   = (baud_cnt_q == BAUD_LAST);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      ovf_d    = ovf_q | (TxD_start & ~push_ok);
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      txd_d      = 1'b1;
      done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      // TxD is registered from the current state, so the line trails the
      // state register by one cycle.
      case (state_q)
         S_IDLE: begin
            txd_d      = 1'b1;
            baud_cnt_d = '0;
            if (!fifo_empty) begin
               shift_d   = head;
               bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^head;
`endif
               state_d   = S_START;
            end
         end
         S_START: begin
            txd_d = 1'b0;
            if (bit_tick) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            txd_d = shift_q[0];
            if (bit_tick) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            txd_d = parity_q;
            if (bit_tick) begin
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            txd_d = 1'b1;
            if (bit_tick) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   always_ff @(posedge HCLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= TxD_data;
      end
   end

   assign TxD       = txd_q;
   assign TxD_done  = done_q;
   assign TxD_busy  = (state_q != S_IDLE) || !fifo_empty;
   assign fifo_full = full;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo. A line receiver decodes TxD at
// mid-bit and queues what it sees; each scenario task compares that queue,
// the status outputs and (for a single frame) the exact TxD waveform against
// values derived from the frame format and FIFO rules. Also covers the 8E1
// build when UART_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int DEPTH    = 4;
   localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS    = 11;
`else
   localparam int NBITS    = 10;
`endif
   localparam int FRAME    = NBITS * CPB;

   logic       HCLK      = 1'b0;
   logic       HRESET    = 1'b0;
   logic       TxD_start = 1'b0;
   logic [7:0] TxD_data  = 8'h00;
   logic       TxD;
   logic       TxD_busy;
   logic       TxD_done;
   logic       fifo_full;
   logic       overflow;

   uart_tx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .TxD_start (TxD_start),
      .TxD_data  (TxD_data),
      .TxD       (TxD),
      .TxD_busy  (TxD_busy),
      .TxD_done  (TxD_done),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- line receiver ----------------
   logic [7:0] rx_q[$];
   bit         rx_ok[$];
   bit         rx_par[$];
   int         rx_t[$];
   bit         mon_busy = 1'b0;
   int         rst_cnt  = 0;

   initial forever begin
      @(negedge HRESET);
      rst_cnt = rst_cnt + 1;
   end

   initial begin : line_rx
      logic       prev;
      logic [7:0] b;
      bit         ok;
      bit         p;
      int         t0;
      int         r0;
      prev = 1'b1;
      forever begin
         @(negedge HCLK);
         if (HRESET === 1'b1 && prev === 1'b1 && TxD === 1'b0) begin
            mon_busy = 1'b1;
            t0 = cyc;
            r0 = rst_cnt;
            ok = 1'b1;
            repeat (CPB / 2) @(negedge HCLK);
            if (TxD !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge HCLK);
               b[i] = TxD;
            end
            p = 1'b0;
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge HCLK);
            p = TxD;
`endif
            repeat (CPB) @(negedge HCLK);
            if (TxD !== 1'b1) ok = 1'b0;
            if (rst_cnt == r0) begin
               rx_q.push_back(b);
               rx_ok.push_back(ok);
               rx_par.push_back(p);
               rx_t.push_back(t0);
            end
            mon_busy = 1'b0;
         end
         prev = TxD;
      end
   end

   // ---------------- helpers (no comparisons) ----------------
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_ok.delete();
      rx_par.delete();
      rx_t.delete();
   endtask

   task automatic apply_reset();
      TxD_start = 1'b0;
      HRESET    = 1'b0;
      repeat (3) tick();
      HRESET    = 1'b1;
      tick();
      clear_rx();
   endtask

   task automatic push(input logic [7:0] d);
      TxD_start = 1'b1;
      TxD_data  = d;
      tick();
      TxD_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (TxD_busy === 1'b0 && !mon_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      HRESET = 1'b0;
      repeat (2) tick();
      n_cmp++; if (TxD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", TxD); end
      n_cmp++; if (TxD_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", TxD_busy); end
      n_cmp++; if (TxD_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", TxD_done); end
      n_cmp++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo_full); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      HRESET = 1'b1;
      repeat (3) tick();
      n_cmp++; if (TxD !== 1'b1 || TxD_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: txd %b busy %b want 1 0", TxD, TxD_busy); end
      $display("test_reset done");
   endtask

   // Cycle-exact frame check: push at edge k, line low from edge k+2, done
   // and busy-fall on edge k+1+FRAME.
   task automatic test_single_byte(input logic [7:0] b);
      logic exp_bits[NBITS];
      int   k;
      logic exp_txd;
      logic exp_done;
      logic exp_busy;
      bit   ok;
      clear_rx();
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
      exp_bits[9] = ^b;
`endif
      exp_bits[NBITS - 1] = 1'b1;
      push(b);
      k = cyc;
      for (int e = k + 1; e <= k + 3 + FRAME; e++) begin
         tick();
         exp_txd  = (e >= k + 2 && e <= k + 1 + FRAME) ? exp_bits[(e - k - 2) / CPB] : 1'b1;
         exp_done = (e == k + 1 + FRAME);
         exp_busy = (e <= k + FRAME);
         n_cmp++; if (TxD !== exp_txd) begin n_fail++; $display("FAIL wave_txd @edge+%0d: got %b want %b", e - k, TxD, exp_txd); end
         n_cmp++; if (TxD_done !== exp_done) begin n_fail++; $display("FAIL wave_done @edge+%0d: got %b want %b", e - k, TxD_done, exp_done); end
         n_cmp++; if (TxD_busy !== exp_busy) begin n_fail++; $display("FAIL wave_busy @edge+%0d: got %b want %b", e - k, TxD_busy, exp_busy); end
      end
      wait_idle(50, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_idle: timeout waiting for idle"); end
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== b || !rx_ok[0]) begin
         n_fail++;
         $display("FAIL single_rx: got %0d frames first %h want 1 frame %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
      end
      $display("test_single_byte %h: line frame of %0d cycles checked", b, FRAME);
   endtask

   task automatic test_burst_overflow();
      bit ok;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         TxD_start = 1'b1;
         TxD_data  = 8'(i);
         tick();
      end
      TxD_start = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_ovf: got %b want 1", overflow); end
      n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL burst_full: got %b want 1", fifo_full); end
      wait_idle(6 * FRAME + 50, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL burst_idle: timeout waiting for idle"); end
      n_cmp++; if (rx_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", rx_q.size(), DEPTH + 1); end
      for (int i = 0; i < rx_q.size() && i < DEPTH + 1; i++) begin
         n_cmp++; if (rx_q[i] !== 8'(i) || !rx_ok[i]) begin n_fail++; $display("FAIL burst_byte[%0d]: got %h ok %0d want %h", i, rx_q[i], rx_ok[i], 8'(i)); end
         if (i > 0) begin
            n_cmp++; if (rx_t[i] - rx_t[i - 1] != FRAME + 1) begin n_fail++; $display("FAIL burst_gap[%0d]: got %0d want %0d", i, rx_t[i] - rx_t[i - 1], FRAME + 1); end
         end
      end
      $display("test_burst_overflow: %0d frames received", rx_q.size());
   endtask

   task automatic test_full_simul_pop();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      int         k;
      bit         seen;
      bit         ok;
      apply_reset();
      d = 8'($urandom);
      exp_q.push_back(d);
      push(d);
      k = cyc;
      while (cyc < k + FRAME - 9) tick();
      // Four pushes land while the first frame is in its stop bit.
      for (int j = 0; j < DEPTH; j++) begin
         d = 8'($urandom);
         exp_q.push_back(d);
         push(d);
      end
      n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fsp_full_before: got %b want 1", fifo_full); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fsp_ovf_before: got %b want 0", overflow); end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (TxD_done === 1'b1) seen = 1'b1;
         else tick();
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL fsp_done: no done pulse within budget"); end
      // Push on the edge that pops the head entry.
      d = 8'($urandom);
      exp_q.push_back(d);
      push(d);
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fsp_ovf_after: got %b want 0", overflow); end
      n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fsp_full_after: got %b want 1", fifo_full); end
      // No pop now; this one must be dropped.
      push(8'($urandom));
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fsp_ovf_drop: got %b want 1", overflow); end
      wait_idle(8 * FRAME, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL fsp_idle: timeout waiting for idle"); end
      n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fsp_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fsp_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      $display("test_full_simul_pop: %0d frames received", rx_q.size());
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      int         k;
      int         lows;
      apply_reset();
      d = 8'($urandom);
      push(d);
      k = cyc;
      push(8'($urandom));
      push(8'($urandom));
      while (cyc < k + 2 + 4 * CPB + 3) tick();
      n_cmp++; if (TxD !== d[3]) begin n_fail++; $display("FAIL rmf_bit3: got %b want %b", TxD, d[3]); end
      #2;
      HRESET = 1'b0;
      #1;
      n_cmp++; if (TxD !== 1'b1) begin n_fail++; $display("FAIL rmf_txd: got %b want 1", TxD); end
      n_cmp++; if (TxD_busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy: got %b want 0", TxD_busy); end
      n_cmp++; if (TxD_done !== 1'b0) begin n_fail++; $display("FAIL rmf_done: got %b want 0", TxD_done); end
      n_cmp++; if (fifo_full !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rmf_status: full %b ovf %b want 0 0", fifo_full, overflow); end
      repeat (2) tick();
      HRESET = 1'b1;
      lows = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (TxD !== 1'b1) lows++;
      end
      n_cmp++; if (lows != 0) begin n_fail++; $display("FAIL rmf_quiet: got %0d non-idle cycles want 0", lows); end
      n_cmp++; if (TxD_busy !== 1'b0) begin n_fail++; $display("FAIL rmf_empty: busy %b want 0", TxD_busy); end
      n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rmf_rx: got %0d frames want 0", rx_q.size()); end
      $display("test_reset_mid_frame: byte %h aborted at bit 3", d);
   endtask

   // Consecutive pushes into an idle, empty FIFO: the first is popped at
   // once, so DEPTH+1 are accepted and the rest are dropped.
   task automatic test_random_bursts();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      int         n;
      bit         ok;
      for (int it = 0; it < 8; it++) begin
         apply_reset();
         exp_q.delete();
         n = $urandom_range(1, DEPTH + 3);
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (i < DEPTH + 1) exp_q.push_back(d);
            TxD_start = 1'b1;
            TxD_data  = d;
            tick();
         end
         TxD_start = 1'b0;
         n_cmp++; if (overflow !== (n > DEPTH + 1)) begin n_fail++; $display("FAIL rnd_ovf[%0d] n=%0d: got %b want %b", it, n, overflow, (n > DEPTH + 1)); end
         wait_idle((DEPTH + 2) * FRAME, ok);
         n_cmp++; if (!ok) begin n_fail++; $display("FAIL rnd_idle[%0d]: timeout waiting for idle", it); end
         n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", it, rx_q.size(), exp_q.size()); end
         for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin n_fail++; $display("FAIL rnd_byte[%0d][%0d]: got %h ok %0d want %h", it, i, rx_q[i], rx_ok[i], exp_q[i]); end
         end
         $display("test_random_bursts %0d: pushed %0d, expected %0d frames", it, n, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      bit         ok;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         exp_q.push_back(d);
         push(d);
         wait_idle(2 * FRAME, ok);
         n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_idle[%0d]: timeout waiting for idle", i); end
      end
      n_cmp++; if (rx_q.size() != 10) begin n_fail++; $display("FAIL wrap_count: got %0d want 10", rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < 10; i++) begin
         n_cmp++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin n_fail++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      $display("test_wrap: %0d bytes across pointer wrap", rx_q.size());
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals[4];
      int         k;
      bit         ok;
      bit         seen;
      vals[0] = 8'h07;
      vals[1] = 8'h03;
      vals[2] = 8'($urandom);
      vals[3] = 8'($urandom);
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         push(vals[i]);
         k = cyc;
         seen = 1'b0;
         for (int j = 0; j < FRAME + 20 && !seen; j++) begin
            tick();
            if (TxD_done === 1'b1) seen = 1'b1;
         end
         n_cmp++; if (!seen || cyc - k != FRAME + 1) begin n_fail++; $display("FAIL par_len[%0d]: done at +%0d want +%0d", i, cyc - k, FRAME + 1); end
         wait_idle(50, ok);
      end
      n_cmp++; if (rx_q.size() != 4) begin n_fail++; $display("FAIL par_count: got %0d want 4", rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < 4; i++) begin
         n_cmp++; if (rx_q[i] !== vals[i] || rx_par[i] !== ^vals[i]) begin n_fail++; $display("FAIL par_bit[%0d]: got %h p%0d want %h p%0d", i, rx_q[i], rx_par[i], vals[i], ^vals[i]); end
      end
      $display("test_parity: %0d frames with parity", rx_q.size());
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_byte(8'h42);
      test_single_byte(8'($urandom));
      test_burst_overflow();
      test_full_simul_pop();
      test_reset_mid_frame();
      test_random_bursts();
      test_wrap();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
